// File: rtl/mul4_eval_pkg.sv
// rtl/mul4_eval_pkg.sv - operand patterns, golden lanes and FSM states for mul4_fitness_eval
package mul4_eval_pkg;

  localparam int LANES = 4;

  localparam logic [15:0] PAT_A1 = 16'hFF00;
  localparam logic [15:0] PAT_A0 = 16'hF0F0;
  localparam logic [15:0] PAT_B1 = 16'hCCCC;
  localparam logic [15:0] PAT_B0 = 16'hAAAA;

  localparam logic [15:0] G3 = 16'h8000;
  localparam logic [15:0] G2 = 16'h4C00;
  localparam logic [15:0] G1 = 16'h6AC0;
  localparam logic [15:0] G0 = 16'hA0A0;

  localparam logic [LANES-1:0][15:0] GOLDEN = {G3, G2, G1, G0};

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    SCORE,
    DONE
  } state_t;

endpackage

// File: rtl/popcount16.sv
// rtl/popcount16.sv - combinational population count of a 16-bit word
module popcount16 (
  input  logic [15:0] data,
  output logic [4:0]  count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < 16; i++) begin
      count = count + {4'b0000, data[i]};
    end
  end

endmodule

// File: rtl/mul4_fitness_eval.sv
// rtl/mul4_fitness_eval.sv - sequencer/scorer for a 2x2-bit multiplier candidate
// Optional per-lane error output: define MUL4_EVAL_LANE_ERR_EN.
module mul4_fitness_eval
  import mul4_eval_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int ID_W          = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [ID_W-1:0] cand_id,
  input  logic            clear_best,
  output logic [15:0]     drv_a1,
  output logic [15:0]     drv_a0,
  output logic [15:0]     drv_b1,
  output logic [15:0]     drv_b0,
  input  logic [15:0]     y3,
  input  logic [15:0]     y2,
  input  logic [15:0]     y1,
  input  logic [15:0]     y0,
  output logic            busy,
  output logic            done,
  output logic [6:0]      fitness,
  output logic            perfect,
  output logic [6:0]      best_fitness,
`ifdef MUL4_EVAL_LANE_ERR_EN
  output logic [LANES-1:0][4:0] lane_err,
`endif
  output logic [ID_W-1:0] best_id
);

  state_t                  state, state_nxt;
  logic [3:0]              settle_cnt;
  logic [1:0]              lane;
  logic [ID_W-1:0]         id_q;
  logic [6:0]              acc;
  logic [6:0]              acc_sum;
  logic [LANES-1:0][15:0]  cap;
  logic [15:0]             lane_match;
  logic [4:0]              match_cnt;
  logic [6:0]              best_fit_q;
  logic [ID_W-1:0]         best_id_q;
  logic                    take_best;
`ifdef MUL4_EVAL_LANE_ERR_EN
  logic [LANES-2:0][4:0]   err_sh;
`endif

  assign lane_match = ~(cap[lane] ^ GOLDEN[lane]);

  popcount16 u_popcount (
    .data  (lane_match),
    .count (match_cnt)
  );

  assign acc_sum = acc + {2'b00, match_cnt};

  // A new best is shown during DONE and committed at its end, so clear_best in
  // that same cycle can still veto the update.
  assign take_best    = (state == DONE) && !clear_best && (acc > best_fit_q);
  assign best_fitness = take_best ? acc  : best_fit_q;
  assign best_id      = take_best ? id_q : best_id_q;

  assign busy   = (state != IDLE);
  assign done   = (state == DONE);
  assign drv_a1 = busy ? PAT_A1 : 16'h0000;
  assign drv_a0 = busy ? PAT_A0 : 16'h0000;
  assign drv_b1 = busy ? PAT_B1 : 16'h0000;
  assign drv_b0 = busy ? PAT_B0 : 16'h0000;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SETTLE;
      SETTLE:  if (settle_cnt == 4'd1) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = SCORE;
      SCORE:   if (lane == 2'd3) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      settle_cnt <= '0;
      lane       <= '0;
      id_q       <= '0;
      acc        <= '0;
      cap        <= '0;
      fitness    <= '0;
      perfect    <= 1'b0;
      best_fit_q <= '0;
      best_id_q  <= '0;
`ifdef MUL4_EVAL_LANE_ERR_EN
      err_sh     <= '0;
      lane_err   <= '0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            id_q       <= cand_id;
            acc        <= '0;
            lane       <= '0;
            settle_cnt <= 4'(SETTLE_CYCLES);
          end
        end
        SETTLE: settle_cnt <= settle_cnt - 4'd1;
        SAMPLE: cap <= {y3, y2, y1, y0};
        SCORE: begin
          acc  <= acc_sum;
          lane <= lane + 2'd1;
          // Results land on the edge into DONE so they are valid with done.
          if (lane == 2'd3) begin
            fitness <= acc_sum;
            perfect <= (acc_sum == 7'd64);
          end
`ifdef MUL4_EVAL_LANE_ERR_EN
          err_sh <= {5'd16 - match_cnt, err_sh[LANES-2:1]};
          if (lane == 2'd3) lane_err <= {5'd16 - match_cnt, err_sh};
`endif
        end
        DONE: begin
          if (take_best) begin
            best_fit_q <= acc;
            best_id_q  <= id_q;
          end
        end
        default: ;
      endcase
      if (clear_best) begin
        best_fit_q <= '0;
        best_id_q  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mul4_fitness_eval.sv
// tb/tb_mul4_fitness_eval.sv - self-checking bench for mul4_fitness_eval
module tb_mul4_fitness_eval;

  logic        clk = 1'b0;
  logic        rst_n, start, clear_best;
  logic [7:0]  cand_id;
  logic [15:0] y3, y2, y1, y0;
  logic [15:0] drv_a1, drv_a0, drv_b1, drv_b0;
  logic        busy, done, perfect;
  logic [6:0]  fitness, best_fitness;
  logic [7:0]  best_id;
`ifdef MUL4_EVAL_LANE_ERR_EN
  logic [3:0][4:0] lane_err;
`endif

  int checks = 0;
  int errors = 0;

  logic [6:0]  m_best_fit;
  logic [7:0]  m_best_id;

  logic [6:0]  s_fit, s_bfit;
  logic        s_perf, s_busy;
  logic [7:0]  s_bid;
  logic [63:0] s_drv;
  int          s_done_cyc, s_n_done;

  always #5 clk = ~clk;

  mul4_fitness_eval #(.SETTLE_CYCLES(2), .ID_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .cand_id      (cand_id),
    .clear_best   (clear_best),
    .drv_a1       (drv_a1),
    .drv_a0       (drv_a0),
    .drv_b1       (drv_b1),
    .drv_b0       (drv_b0),
    .y3           (y3),
    .y2           (y2),
    .y1           (y1),
    .y0           (y0),
    .busy         (busy),
    .done         (done),
    .fitness      (fitness),
    .perfect      (perfect),
    .best_fitness (best_fitness),
`ifdef MUL4_EVAL_LANE_ERR_EN
    .lane_err     (lane_err),
`endif
    .best_id      (best_id)
  );

  // Reference: bit k of each lane is case a=k/4, b=k%4; lane l must equal bit l of a*b.
  function automatic int model_lane_ok(input int l, input logic [15:0] v);
    int ok = 0;
    for (int k = 0; k < 16; k++) begin
      int p = (k / 4) * (k % 4);
      if (((p >> l) & 1) == int'(v[k])) ok++;
    end
    return ok;
  endfunction

  function automatic int model_fit(input logic [15:0] v3, v2, v1, v0);
    return model_lane_ok(3, v3) + model_lane_ok(2, v2) + model_lane_ok(1, v1) + model_lane_ok(0, v0);
  endfunction

  task automatic model_record(input int f, input logic [7:0] id);
    if (f > int'(m_best_fit)) begin
      m_best_fit = 7'(f);
      m_best_id  = id;
    end
  endtask

  task automatic set_golden();
    y3 = 16'h8000; y2 = 16'h4C00; y1 = 16'h6AC0; y0 = 16'hA0A0;
  endtask

  // Start one evaluation and observe 14 cycles, snapshotting the first done cycle.
  task automatic run_eval(input logic [7:0] id, input logic [15:0] pulse_mask,
                          input bit scramble, input bit clr_at_done);
    @(negedge clk);
    cand_id = id;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    cand_id = 8'h55;
    s_done_cyc = 0;
    s_n_done   = 0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c == 1) begin
        s_drv  = {drv_a1, drv_a0, drv_b1, drv_b0};
        s_busy = busy;
      end
      if (done) begin
        s_n_done++;
        if (s_done_cyc == 0) begin
          s_done_cyc = c;
          s_fit  = fitness;
          s_perf = perfect;
          s_bfit = best_fitness;
          s_bid  = best_id;
        end
      end
      start      = pulse_mask[c];
      clear_best = clr_at_done && done;
      if (scramble && c == 4) {y3, y2, y1, y0} = {$urandom, $urandom};
    end
    start      = 1'b0;
    clear_best = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear_best = 1'b1;
    @(negedge clk);
    clear_best = 1'b0;
    m_best_fit = '0;
    m_best_id  = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; clear_best = 1'b0; cand_id = '0;
    y3 = '0; y2 = '0; y1 = '0; y0 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, perfect} !== 3'b000 || {drv_a1, drv_a0, drv_b1, drv_b0} !== 64'h0 ||
        fitness !== 7'd0 || best_fitness !== 7'd0 || best_id !== 8'd0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b perf=%b drv=%h fit=%0d best=%0d id=%0d, want all 0",
               busy, done, perfect, {drv_a1, drv_a0, drv_b1, drv_b0}, fitness, best_fitness, best_id);
    end
    rst_n = 1'b1;
    m_best_fit = '0;
    m_best_id  = '0;
  endtask

  task automatic test_golden();
    set_golden();
    run_eval(8'h01, 16'h0, 1'b0, 1'b0);
    model_record(64, 8'h01);
    checks++;
    if (s_done_cyc != 8) begin
      errors++; $display("FAIL golden_latency: got cycle %0d want 8", s_done_cyc);
    end
    checks++;
    if (s_fit !== 7'd64 || s_perf !== 1'b1) begin
      errors++; $display("FAIL golden_fitness: got %0d/%b want 64/1", s_fit, s_perf);
    end
    checks++;
    if (s_drv !== {16'hFF00, 16'hF0F0, 16'hCCCC, 16'hAAAA} || s_busy !== 1'b1) begin
      errors++; $display("FAIL drive_pattern: got %h busy %b want ff00f0f0ccccaaaa busy 1", s_drv, s_busy);
    end
    checks++;
    if (s_n_done != 1 || busy !== 1'b0 || drv_a1 !== 16'h0) begin
      errors++; $display("FAIL golden_single_done: dones %0d busy %b drv_a1 %h want 1/0/0000", s_n_done, busy, drv_a1);
    end
  endtask

  task automatic test_constant_lanes();
    y3 = 16'h0000; y2 = 16'h0000; y1 = 16'h0000; y0 = 16'h0000;
    run_eval(8'h02, 16'h0, 1'b0, 1'b0);
    checks++;
    if (s_fit !== 7'd50 || s_perf !== 1'b0) begin
      errors++; $display("FAIL all_zero: got %0d/%b want 50/0", s_fit, s_perf);
    end
    y3 = 16'hFFFF; y2 = 16'hFFFF; y1 = 16'hFFFF; y0 = 16'hFFFF;
    run_eval(8'h04, 16'h0, 1'b0, 1'b0);
    checks++;
    if (s_fit !== 7'd14 || s_perf !== 1'b0) begin
      errors++; $display("FAIL all_ones: got %0d/%b want 14/0", s_fit, s_perf);
    end
  endtask

  task automatic test_tournament();
    pulse_clear();
    y3 = 16'h0000; y2 = 16'h0000; y1 = 16'h0000; y0 = 16'h0000;
    run_eval(8'd3, 16'h0, 1'b0, 1'b0);
    model_record(50, 8'd3);
    checks++;
    if (s_bfit !== 7'd50 || s_bid !== 8'd3) begin
      errors++; $display("FAIL tourn_first: got %0d/%0d want 50/3", s_bfit, s_bid);
    end
    set_golden();
    run_eval(8'd7, 16'h0, 1'b0, 1'b0);
    model_record(64, 8'd7);
    run_eval(8'd9, 16'h0, 1'b0, 1'b0);
    model_record(64, 8'd9);
    checks++;
    if (s_bfit !== 7'd64 || s_bid !== 8'd7) begin
      errors++; $display("FAIL tourn_tie: got %0d/%0d want 64/7", s_bfit, s_bid);
    end
    checks++;
    if (best_fitness !== m_best_fit || best_id !== m_best_id) begin
      errors++; $display("FAIL tourn_hold: got %0d/%0d want %0d/%0d", best_fitness, best_id, m_best_fit, m_best_id);
    end
  endtask

  task automatic test_ignored_start();
    logic [15:0] v3, v2, v1, v0;
    int exp;
    pulse_clear();
    set_golden();
    y1 = y1 ^ (16'h1 << $urandom_range(15, 0));
    {v3, v2, v1, v0} = {y3, y2, y1, y0};
    exp = model_fit(v3, v2, v1, v0);
    // Pulses land in SETTLE, SCORE and DONE; y is scrambled after SAMPLE.
    run_eval(8'h21, 16'h0122, 1'b1, 1'b0);
    model_record(exp, 8'h21);
    checks++;
    if (s_n_done != 1 || s_done_cyc != 8) begin
      errors++; $display("FAIL ignored_start_dones: got %0d at cycle %0d want 1 at 8", s_n_done, s_done_cyc);
    end
    checks++;
    if (int'(s_fit) != exp || s_bid !== 8'h21) begin
      errors++; $display("FAIL ignored_start_result: got %0d id %h want %0d id 21", s_fit, s_bid, exp);
    end
  endtask

  task automatic test_reset_mid();
    int n_done = 0;
    int exp;
    set_golden();
    @(negedge clk);
    cand_id = 8'h44;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_best_fit = '0;
    m_best_id  = '0;
    checks++;
    if ({busy, done, perfect} !== 3'b000 || {drv_a1, drv_a0, drv_b1, drv_b0} !== 64'h0 ||
        fitness !== 7'd0 || best_fitness !== 7'd0 || best_id !== 8'd0) begin
      errors++;
      $display("FAIL reset_mid_state: busy=%b done=%b perf=%b drv=%h fit=%0d best=%0d, want all 0",
               busy, done, perfect, {drv_a1, drv_a0, drv_b1, drv_b0}, fitness, best_fitness);
    end
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    checks++;
    if (n_done != 0) begin
      errors++; $display("FAIL reset_mid_no_done: got %0d dones want 0", n_done);
    end
    {y3, y2, y1, y0} = {$urandom, $urandom};
    exp = model_fit(y3, y2, y1, y0);
    run_eval(8'h45, 16'h0, 1'b0, 1'b0);
    model_record(exp, 8'h45);
    checks++;
    if (int'(s_fit) != exp || s_done_cyc != 8 || s_bid !== m_best_id) begin
      errors++; $display("FAIL reset_mid_recover: got %0d cyc %0d id %h want %0d cyc 8 id %h",
                         s_fit, s_done_cyc, s_bid, exp, m_best_id);
    end
  endtask

  task automatic test_clear_in_done();
    int exp;
    set_golden();
    y3 = 16'h0000;
    exp = model_fit(y3, y2, y1, y0);
    run_eval(8'h66, 16'h0, 1'b0, 1'b1);
    m_best_fit = '0;
    m_best_id  = '0;
    checks++;
    if (best_fitness !== 7'd0 || best_id !== 8'd0 || int'(fitness) != exp) begin
      errors++; $display("FAIL clear_in_done: best %0d id %0d fit %0d want 0/0/%0d",
                         best_fitness, best_id, fitness, exp);
    end
  endtask

  task automatic test_random();
    int exp;
    logic [7:0] id;
    for (int i = 0; i < 10; i++) begin
      set_golden();
      y3 = y3 ^ 16'($urandom & $urandom & $urandom);
      y2 = y2 ^ 16'($urandom & $urandom & $urandom);
      y1 = y1 ^ 16'($urandom & $urandom);
      y0 = (i % 3 == 0) ? y0 : 16'($urandom);
      id = 8'($urandom);
      exp = model_fit(y3, y2, y1, y0);
      run_eval(id, 16'h0, 1'b0, 1'b0);
      model_record(exp, id);
      checks++;
      if (int'(s_fit) != exp || s_perf !== (exp == 64)) begin
        errors++; $display("FAIL random_fit[%0d]: got %0d/%b want %0d/%b", i, s_fit, s_perf, exp, exp == 64);
      end
      checks++;
      if (s_bfit !== m_best_fit || s_bid !== m_best_id) begin
        errors++; $display("FAIL random_best[%0d]: got %0d/%h want %0d/%h", i, s_bfit, s_bid, m_best_fit, m_best_id);
      end
    end
  endtask

  task automatic test_back_to_back();
    int d1 = 0, d2 = 0, exp;
    {y3, y2, y1, y0} = {$urandom, $urandom};
    exp = model_fit(y3, y2, y1, y0);
    @(negedge clk);
    cand_id = 8'h77;
    start   = 1'b1;
    for (int c = 1; c <= 30 && d2 == 0; c++) begin
      @(negedge clk);
      if (done) begin
        if (d1 == 0) d1 = c; else d2 = c;
        checks++;
        if (int'(fitness) != exp) begin
          errors++; $display("FAIL b2b_fit: got %0d want %0d", fitness, exp);
        end
      end
    end
    start = 1'b0;
    model_record(exp, 8'h77);
    checks++;
    if (d1 == 0 || d2 - d1 != 9) begin
      errors++; $display("FAIL b2b_period: got %0d want 9 (first done %0d)", d2 - d1, d1);
    end
    repeat (12) @(negedge clk);
  endtask

`ifdef MUL4_EVAL_LANE_ERR_EN
  task automatic test_lane_err();
    set_golden();
    y0 = 16'hA0A1;
    run_eval(8'h88, 16'h0, 1'b0, 1'b0);
    checks++;
    if (lane_err !== {5'd0, 5'd0, 5'd0, 5'd1} || s_fit !== 7'd63) begin
      errors++; $display("FAIL lane_err_single: got %h fit %0d want 00001 fit 63", lane_err, s_fit);
    end
    {y3, y2, y1, y0} = {$urandom, $urandom};
    run_eval(8'h89, 16'h0, 1'b0, 1'b0);
    for (int l = 0; l < 4; l++) begin
      int want;
      want = 16 - model_lane_ok(l, (l == 0) ? y0 : (l == 1) ? y1 : (l == 2) ? y2 : y3);
      checks++;
      if (int'(lane_err[l]) != want) begin
        errors++; $display("FAIL lane_err_rand[%0d]: got %0d want %0d", l, lane_err[l], want);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_golden();
    test_constant_lanes();
    test_tournament();
    test_ignored_start();
    test_reset_mid();
    test_clear_in_done();
    test_random();
    test_back_to_back();
`ifdef MUL4_EVAL_LANE_ERR_EN
    test_lane_err();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul4_fitness_eval.md
# mul4_fitness_eval

Sequencer and scorer for one evolved 2x2-bit vector multiplier candidate (16-bit bit-sliced lanes a1/a0/b1/b0 in, y3..y0 out). It drives the exhaustive 16-case operand pattern into the combinational candidate and waits a programmable settle time. It then samples the four product lanes, scores correct bits against the golden product one lane per cycle, and keeps the best candidate seen for tournament selection. It sits between the tournament controller and the candidate under evaluation.

## Interface
- SETTLE_CYCLES, 2: cycles the candidate is given to settle before sampling; legal 1..15.
- ID_W, 8: width of candidate identifier.

- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  begin evaluation; sampled only in IDLE.
- cand_id  in  ID_W  identifier of candidate; captured with start.
- clear_best  in  1  zero best_fitness/best_id; lower priority than rst_n, higher than a same-cycle best update.
- drv_a1, drv_a0, drv_b1, drv_b0  out  16 each  operand patterns to candidate.
- y3, y2, y1, y0  in  16 each  candidate product lanes.
- busy  out  1  high in every non-IDLE state.
- done  out  1  one-cycle pulse, result valid.
- fitness  out  7  correct bits of last evaluation, 0..64.
- perfect  out  1  fitness == 64; updates with fitness.
- best_fitness  out  7  highest fitness since reset/clear.
- best_id  out  ID_W  cand_id that produced best_fitness.

## Operation
- Bit k of every lane is test case k: a = k[3:2], b = k[1:0], p = a*b (4-bit).
- Operand patterns: a1 = 16'hFF00, a0 = 16'hF0F0, b1 = 16'hCCCC, b0 = 16'hAAAA.
  - Driven in all non-IDLE states.
  - 16'h0000 in IDLE and under reset.
- Golden lanes: G3 = 16'h8000, G2 = 16'h4C00, G1 = 16'h6AC0, G0 = 16'hA0A0.
- FSM: IDLE -> SETTLE -> SAMPLE -> SCORE -> DONE -> IDLE.
  - IDLE: on start, capture cand_id, clear accumulator, load settle counter with SETTLE_CYCLES.
  - SETTLE: decrement the counter each cycle; leave when it expires.
  - SAMPLE: register y3..y0 into a capture register.
  - SCORE: 2-bit lane index 0..3; each cycle, accumulator += popcount(~(cap[i] ^ G[i])).
  - DONE: fitness <= accumulator, perfect updated, done = 1.
    - If accumulator > best_fitness, best_fitness/best_id <= accumulator/captured id.
    - Ties keep the earlier candidate.
- start while busy is ignored, including in DONE; no queueing.
- Candidate outputs are read only in SAMPLE; changes in y during SCORE have no effect.
- Accumulator is 7 bits; max 64, so no overflow handling.
- clear_best in the DONE cycle zeroes best, and that evaluation is not recorded.

## Timing
- start sampled at edge E0:
  - SETTLE occupies cycles 1..SETTLE_CYCLES.
  - SAMPLE is cycle SETTLE_CYCLES+1.
  - SCORE is cycles SETTLE_CYCLES+2..+5.
  - done is high in cycle SETTLE_CYCLES+6; default 8 cycles after start.
- fitness, perfect and best_* change in the cycle done is high, then hold until the next DONE.
- Back-to-back: a new start is accepted the cycle after DONE; evaluation period is SETTLE_CYCLES+7.
- Reset values: state IDLE, busy 0, done 0, drv_* 0, fitness 0, perfect 0, best_fitness 0, best_id 0, lane-error outputs 0.
- Reset mid-evaluation: abort next cycle; no done pulse, results zeroed.

## Configuration
- MUL4_EVAL_LANE_ERR_EN defined:
  - Adds output lane_err, 4x5 bits: per-lane error count (0..16) of the last evaluation.
  - Lanes are written during SCORE and presented with done.
  - Reset value 0.
- Undefined: port and registers absent; all other behaviour identical.

## Structure
- Package mul4_eval_pkg holds:
  - pattern constants and golden lane constants G0..G3;
  - LANES = 4;
  - FSM state enum (IDLE, SETTLE, SAMPLE, SCORE, DONE).
- One sub-module: popcount16 (16-bit in, 5-bit count out, combinational), instantiated once on the lane-mux output.

## Test plan
- Model drives y = golden (y3..y0 = 8000/4C00/6AC0/A0A0) -> fitness 64, perfect 1, done exactly 8 cycles after start with SETTLE_CYCLES = 2.
- y all 16'h0000 -> fitness 50; y all 16'hFFFF -> fitness 14; perfect 0 in both cases.
- cand_id 3 scores 50, then cand_id 7 scores 64, then cand_id 9 scores 64 -> best_id 7, best_fitness 64 after the third done.
- start pulsed during SETTLE and SCORE of a running evaluation -> exactly one done, fitness from the first start only.
- rst_n low for one cycle during SCORE -> no done, all outputs 0, drv_* 0; a following start evaluates normally.
- With MUL4_EVAL_LANE_ERR_EN, y0 = 16'hA0A1 and other lanes golden -> lane_err[0] = 1, others 0, fitness 63.
